cronometro_voltas: RTL

//  Parametrised lap stopwatch, the next generation of the team's stopwatch block. Counts tenths and BCD seconds from a

---
 rtl/cronometro_pkg.sv | 21 ++
 rtl/cronometro_botao.sv | 58 +++++
 rtl/cronometro_voltas.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cronometro_pkg.sv
// Shared types for the lap stopwatch: FSM states, BCD digit type and button event indices.
// Lower event index wins when several buttons fire in the same cycle.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    CONTAR = 2'd1,
    PARAR  = 2'd2,
    PAUSA  = 2'd3
  } estado_t;

  typedef logic [3:0] bcd_t;

  localparam int N_EV     = 5;
  localparam int EV_RESET = 0;
  localparam int EV_PARA  = 1;
  localparam int EV_PAUSA = 2;
  localparam int EV_CONTA = 3;
  localparam int EV_VOLTA = 4;

endpackage

// File: rtl/cronometro_botao.sv
// Active-low button front end: 2-FF synchroniser, optional debounce, falling-edge event.
// Debounce filter is built only when CRONOMETRO_DEBOUNCE_EN is defined.
module cronometro_botao
`ifdef CRONOMETRO_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYC = 500_000)
`endif
(
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic sync_a;
  logic sync_b;
  logic level;
  logic level_d;

  // Released buttons read high, so the chain resets to 1 to avoid a spurious press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

`ifdef CRONOMETRO_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level      <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_b == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DW'(DEBOUNCE_CYC - 1)) begin
      level      <= sync_b;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + DW'(1);
    end
  end
`else
  assign level = sync_b;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) level_d <= 1'b1;
    else          level_d <= level;
  end

  assign press = level_d & ~level;

endmodule

// File: rtl/cronometro_voltas.sv
// Lap stopwatch: BCD tenths/seconds counter, run/pause/stop FSM and a FWFT lap FIFO.
// Optional button debounce selected with the CRONOMETRO_DEBOUNCE_EN macro.
module cronometro_voltas #(
  parameter int TICK_DIV     = 5_000_000,
  parameter int SEG_DIGITS   = 3,
  parameter int LAP_DEPTH    = 4,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               btn_conta,
  input  logic                               btn_pausa,
  input  logic                               btn_para,
  input  logic                               btn_reset,
  input  logic                               btn_volta,
  output logic                               ESPERA,
  output logic                               CONTAR,
  output logic                               PARAR,
  output logic                               PAUSA,
  output logic [4*SEG_DIGITS-1:0]            display_seg,
  output logic [3:0]                         display_dec_segs,
  output logic                               estouro,
  input  logic                               lap_rd,
  output logic                               lap_valid,
  output logic [4*SEG_DIGITS-1:0]            lap_seg,
  output logic [3:0]                         lap_dec,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count,
  output logic                               lap_overrun
);
  import cronometro_pkg::*;

  localparam int SW = 4 * SEG_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic [N_EV-1:0] btn_vec, ev, ev_win;

  assign btn_vec[EV_RESET] = btn_reset;
  assign btn_vec[EV_PARA]  = btn_para;
  assign btn_vec[EV_PAUSA] = btn_pausa;
  assign btn_vec[EV_CONTA] = btn_conta;
  assign btn_vec[EV_VOLTA] = btn_volta;

  for (genvar i = 0; i < N_EV; i++) begin : g_btn
    cronometro_botao
`ifdef CRONOMETRO_DEBOUNCE_EN
      #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
`endif
      u_botao (
        .clock  (clock),
        .reset_n(reset_n),
        .btn    (btn_vec[i]),
        .press  (ev[i])
      );
  end

  // Keep only the lowest-index (highest-priority) event.
  assign ev_win = ev & (~ev + N_EV'(1));

  estado_t state, state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= cronometro_pkg::ESPERA;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      cronometro_pkg::ESPERA: if (ev_win[EV_CONTA]) state_next = cronometro_pkg::CONTAR;
      cronometro_pkg::CONTAR: begin
        if (ev_win[EV_PARA])       state_next = cronometro_pkg::PARAR;
        else if (ev_win[EV_PAUSA]) state_next = cronometro_pkg::PAUSA;
      end
      cronometro_pkg::PARAR:  if (ev_win[EV_CONTA]) state_next = cronometro_pkg::CONTAR;
      cronometro_pkg::PAUSA:  if (ev_win[EV_PAUSA] || ev_win[EV_CONTA]) state_next = cronometro_pkg::CONTAR;
      default:                state_next = cronometro_pkg::ESPERA;
    endcase
    if (ev_win[EV_RESET]) state_next = cronometro_pkg::ESPERA;
  end

  assign ESPERA = (state == cronometro_pkg::ESPERA);
  assign CONTAR = (state == cronometro_pkg::CONTAR);
  assign PARAR  = (state == cronometro_pkg::PARAR);
  assign PAUSA  = (state == cronometro_pkg::PAUSA);

  logic          running, tick, wrap, clear_all;
  logic [PW-1:0] presc;
  bcd_t          cnt_dec, dec_next;
  logic [SW-1:0] cnt_seg, seg_next;

  assign running   = CONTAR || PAUSA;
  assign tick      = running && (presc == PW'(TICK_DIV - 1));
  assign clear_all = (state_next == cronometro_pkg::ESPERA);

  // BCD ripple increment; wrap is the carry out of the top seconds digit.
  always_comb begin
    dec_next = cnt_dec;
    seg_next = cnt_seg;
    wrap     = 1'b0;
    if (tick) begin
      if (cnt_dec == 4'd9) begin
        dec_next = 4'd0;
        wrap     = 1'b1;
      end else begin
        dec_next = cnt_dec + 4'd1;
      end
      for (int i = 0; i < SEG_DIGITS; i++) begin
        if (wrap) begin
          if (cnt_seg[4*i +: 4] == 4'd9) begin
            seg_next[4*i +: 4] = 4'd0;
          end else begin
            seg_next[4*i +: 4] = cnt_seg[4*i +: 4] + 4'd1;
            wrap               = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc            <= '0;
      cnt_dec          <= '0;
      cnt_seg          <= '0;
      display_seg      <= '0;
      display_dec_segs <= '0;
      estouro          <= 1'b0;
    end else if (clear_all) begin
      presc            <= '0;
      cnt_dec          <= '0;
      cnt_seg          <= '0;
      display_seg      <= '0;
      display_dec_segs <= '0;
      estouro          <= 1'b0;
    end else begin
      if (running) presc <= tick ? '0 : presc + PW'(1);
      cnt_dec <= dec_next;
      cnt_seg <= seg_next;
      if (wrap) estouro <= 1'b1;
      // Display follows the counter in CONTAR and reloads when PAUSA resumes.
      if (CONTAR || (PAUSA && state_next == cronometro_pkg::CONTAR)) begin
        display_seg      <= seg_next;
        display_dec_segs <= dec_next;
      end
    end
  end

  logic          push_req, push, pop, full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] mem_seg [LAP_DEPTH];
  bcd_t          mem_dec [LAP_DEPTH];

  assign push_req = ev_win[EV_VOLTA] && running;
  assign lap_valid = (lap_count != '0);
  assign pop      = lap_rd && lap_valid;
  assign full     = (lap_count == CW'(LAP_DEPTH));
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lap_count   <= '0;
      lap_overrun <= 1'b0;
    end else if (clear_all) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lap_count   <= '0;
      lap_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      lap_count <= lap_count + CW'(1);
      else if (pop && !push) lap_count <= lap_count - CW'(1);
      if (push_req && !push) lap_overrun <= 1'b1;
    end
  end

  // Laps capture the live counter, not the possibly frozen display.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_seg[wr_ptr] <= cnt_seg;
      mem_dec[wr_ptr] <= cnt_dec;
    end
  end

  assign lap_seg = lap_valid ? mem_seg[rd_ptr] : '0;
  assign lap_dec = lap_valid ? mem_dec[rd_ptr] : '0;

endmodule
